error_fifo_arb: RTL and testbench
=================================

// Module: error_fifo_arb
// PURPOSE
//  Parametrised multi-source error collector; successor to the fixed five-source core error FIFO.
//  N_SRC error sources each strobe a report into a one-deep pending register.
//  A fixed-priority arbiter grants one pending report per cycle into a 2**AW-entry RAM FIFO.
//  The core's error handler drains the FIFO through a VALID/ERD read port, with overflow and lost-event accounting.
// PARAMETERS
//  N_SRC  5   number of error sources (1..16); index 0 has highest priority
//  DW     64  error code width, all sources and output
//  AW     6   FIFO address width; depth = 2**AW entries
//  CW     8   width of saturating drop/lost counters
// PORTS
//  CLK       in   1              clock, all logic on rising edge
//  RESET     in   1              asynchronous, active-high reset
//  STB       in   N_SRC          per-source report strobe, 1 cycle per report
//  ECD_IN    in   N_SRC x DW     per-source error code, sampled when STB[i]=1
//  ERD       in   1              read acknowledge; pops the head when VALID=1
//  VALID     out  1              ECD holds a valid head entry
//  ECD       out  DW             head error code (registered)
//  SRC       out  $clog2(N_SRC)  source index of head entry
//  COUNT     out  AW+1           entries stored in the RAM, excluding the output register
//  OVF       out  1              sticky: at least one report dropped because the FIFO was full
//  DROPS     out  CW             saturating count of full-FIFO drops
//  LOST      out  CW             saturating count of strobes rejected while pending was busy
//  CLR       in   1              synchronous clear of OVF, DROPS, LOST
// BEHAVIOUR
//  Reset (RESET=1, async): all pending flags=0, pointers=0, VALID=0, ECD=0, SRC=0, COUNT=0, OVF=0, DROPS=0, LOST=0.
//  Capture, cycle t: STB[i]=1 and pending[i]=0 -> pend data[i]<=ECD_IN[i], pending[i]=1 at t+1.
//   If STB[i]=1 with pending[i]=1 and not granted this cycle -> new report rejected, LOST+1 (saturates at 2**CW-1).
//   If STB[i]=1 while pending[i] is granted the same cycle -> new report accepted, no loss.
//  Grant: the lowest index i with pending[i]=1 is granted; exactly one grant per cycle.
//   When the FIFO is not full, the granted entry {i,data} is written at wptr on that edge; wptr+1, COUNT+1.
//   When the FIFO is full, the granted entry is discarded, pending[i] clears, OVF<=1, DROPS+1 (saturating).
//  Latency: STB at t -> RAM write at t+1 edge -> VALID=1 at t+3 at earliest (RAM read + output register).
//  Read port: the output register loads when VALID=0 or ERD=1.
//   VALID/ERD back-to-back pops sustain 1 entry/cycle with no bubble when COUNT>0.
//   ERD while VALID=0 is ignored.
//  Simultaneous write and read: COUNT is unchanged. Full is COUNT==2**AW; pointers wrap modulo 2**AW.
//  CLR=1: clears OVF, DROPS, LOST. When CLR and a new drop/loss event coincide, the event wins
//   (OVF=1, counter=1).
//  Write-to-read bypass is not provided; an entry written at edge e is readable from RAM no earlier than e+1.
// CONFIGURATION
//  ERRFIFO_TSTAMP_EN defined:
//   - adds a free-running TSW-bit (package constant, 32) cycle counter, reset to 0;
//   - each entry stores the counter value at grant time;
//   - adds output port ETS [TSW-1:0], aligned with ECD/VALID.
//  ERRFIFO_TSTAMP_EN undefined:
//   - no counter and no ETS port; RAM width = DW + $clog2(N_SRC).
// STRUCTURE
//  Package errfifo_pkg:
//   - default parameters;
//   - TSW;
//   - typedef errfifo_entry_t {src, [ts,] code};
//   - saturating-increment function.
//  Sub-module errfifo_ram: simple dual-port, registered-read RAM, one write and one read port,
//   parametrised by AW and entry width.
//  Pending registers, arbiter, pointers and counters stay in error_fifo_arb.
// TESTING
//  1. Single report: STB[2]=1, ECD_IN[2]=64'hDEAD -> VALID=1 at t+3, ECD=64'hDEAD, SRC=2, COUNT=1 before the output load.
//  2. Priority: STB[0], STB[3], STB[4] in the same cycle -> pops in order SRC=0,3,4; LOST=0.
//  3. Lost: STB[1] on 2 consecutive cycles while STB[0] is also busy -> second STB[1] rejected, LOST=1.
//  4. Full: AW=2, 6 reports, ERD=0 -> 4 in RAM + 1 in output, then 1 drop; OVF=1, DROPS=1; CLR -> OVF=0, DROPS=0.
//  5. Streaming: fill to 4, hold ERD=1 -> 4 pops on 4 consecutive cycles; wrap pointer past 2**AW-1 with ordering kept.
//  6. Reset mid-stream: assert RESET while VALID=1 and COUNT=3 -> all outputs 0 immediately; post-reset report works.
//  7. ERRFIFO_TSTAMP_EN: two reports 10 cycles apart -> ETS difference = 10.

Source files
------------

// File: rtl/errfifo_pkg.sv
// rtl/errfifo_pkg.sv - shared defaults, entry layout and saturating helper for the error FIFO.
// ERRFIFO_TSTAMP_EN adds a timestamp field to the entry layout.
package errfifo_pkg;

  localparam int DEF_N_SRC = 5;
  localparam int DEF_DW    = 64;
  localparam int DEF_AW    = 6;
  localparam int DEF_CW    = 8;
  localparam int TSW       = 32;
  localparam int DEF_SW    = $clog2(DEF_N_SRC);

  // Entry layout for the default configuration; the top builds the same layout from its parameters.
  typedef struct packed {
    logic [DEF_SW-1:0] src;
`ifdef ERRFIFO_TSTAMP_EN
    logic [TSW-1:0]    ts;
`endif
    logic [DEF_DW-1:0] code;
  } errfifo_entry_t;

  function automatic logic [31:0] satInc(input logic [31:0] cur,
                                         input logic [31:0] inc,
                                         input logic [31:0] maxVal);
    logic [32:0] sum;
    sum = {1'b0, cur} + {1'b0, inc};
    return (sum > {1'b0, maxVal}) ? maxVal : sum[31:0];
  endfunction

endpackage

// File: rtl/errfifo_ram.sv
// rtl/errfifo_ram.sv - simple dual-port RAM, one write port and one registered read port.
// A read of the address being written on the same edge returns the previous contents.
module errfifo_ram #(
  parameter int AW = 6,
  parameter int EW = 67
) (
  input  logic          CLK,
  input  logic          wrEn,
  input  logic [AW-1:0] wrAddr,
  input  logic [EW-1:0] wrData,
  input  logic [AW-1:0] rdAddr,
  output logic [EW-1:0] rdData
);

  logic [EW-1:0] mem [2**AW];

  always_ff @(posedge CLK) begin
    if (wrEn) mem[wrAddr] <= wrData;
    rdData <= mem[rdAddr];
  end

endmodule

// File: rtl/error_fifo_arb.sv
// rtl/error_fifo_arb.sv - multi-source error collector: pending regs, fixed-priority arbiter, RAM FIFO, read port.
// ERRFIFO_TSTAMP_EN adds a free-running cycle counter stored per entry and the ETS output.
module error_fifo_arb
  import errfifo_pkg::*;
#(
  parameter int N_SRC = DEF_N_SRC,
  parameter int DW    = DEF_DW,
  parameter int AW    = DEF_AW,
  parameter int CW    = DEF_CW
) (
  input  logic                                          CLK,
  input  logic                                          RESET,
  input  logic [N_SRC-1:0]                              STB,
  input  logic [N_SRC*DW-1:0]                           ECD_IN,
  input  logic                                          ERD,
  output logic                                          VALID,
  output logic [DW-1:0]                                 ECD,
`ifdef ERRFIFO_TSTAMP_EN
  output logic [TSW-1:0]                                ETS,
`endif
  output logic [((N_SRC > 1) ? $clog2(N_SRC) : 1)-1:0]  SRC,
  output logic [AW:0]                                   COUNT,
  output logic                                          OVF,
  output logic [CW-1:0]                                 DROPS,
  output logic [CW-1:0]                                 LOST,
  input  logic                                          CLR
);

  localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int DEPTH = 2**AW;
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CW) - 64'd1);

  typedef struct packed {
    logic [SW-1:0]  src;
`ifdef ERRFIFO_TSTAMP_EN
    logic [TSW-1:0] ts;
`endif
    logic [DW-1:0]  code;
  } entry_t;

  localparam int EW = $bits(entry_t);

  logic [N_SRC-1:0] pending;
  logic [DW-1:0]    pendData [N_SRC];
  logic [N_SRC-1:0] grantOh;
  logic [SW-1:0]    grantIdx;
  logic             grantVld;
  logic [N_SRC-1:0] reject;
  logic [4:0]       rejectCnt;
  logic             full;
  logic             wrEn;
  logic             drop;
  logic             outLoad;
  logic             pop;
  logic             dataOk;
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW-1:0]    rdAddr;
  entry_t           wrEntry;
  entry_t           rdEntry;
  logic [31:0]      dropsNext;
  logic [31:0]      lostNext;
`ifdef ERRFIFO_TSTAMP_EN
  logic [TSW-1:0]   tsCnt;
`endif

  // Descending scan so the lowest pending index ends up granted.
  always_comb begin
    grantOh  = '0;
    grantIdx = '0;
    grantVld = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (pending[i]) begin
        grantOh    = '0;
        grantOh[i] = 1'b1;
        grantIdx   = SW'(i);
        grantVld   = 1'b1;
      end
    end
  end

  always_comb begin
    reject    = STB & pending & ~grantOh;
    rejectCnt = '0;
    for (int i = 0; i < N_SRC; i++) rejectCnt = rejectCnt + 5'(reject[i]);
  end

  assign full    = (COUNT == (AW+1)'(DEPTH));
  assign wrEn    = grantVld && !full;
  assign drop    = grantVld && full;
  assign outLoad = !VALID || ERD;
  assign pop     = outLoad && dataOk;
  assign rdAddr  = pop ? rptr + AW'(1) : rptr;

  always_comb begin
    wrEntry      = '0;
    wrEntry.src  = grantIdx;
    wrEntry.code = pendData[grantIdx];
`ifdef ERRFIFO_TSTAMP_EN
    wrEntry.ts   = tsCnt;
`endif
  end

  // A granted slot may be refilled by a strobe on the same edge; otherwise a busy slot rejects.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) pending <= '0;
    else       pending <= (pending & ~grantOh) | STB;
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < N_SRC; i++) begin
      if (STB[i] && (!pending[i] || grantOh[i])) pendData[i] <= ECD_IN[i*DW +: DW];
    end
  end

  // dataOk: the RAM read register holds the entry at rptr, written at least one edge before it was read.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wptr   <= '0;
      rptr   <= '0;
      COUNT  <= '0;
      dataOk <= 1'b0;
    end else begin
      if (wrEn) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      COUNT  <= COUNT + (AW+1)'(wrEn) - (AW+1)'(pop);
      dataOk <= (COUNT - (AW+1)'(pop)) != '0;
    end
  end

  errfifo_ram #(
    .AW (AW),
    .EW (EW)
  ) uRam (
    .CLK    (CLK),
    .wrEn   (wrEn),
    .wrAddr (wptr),
    .wrData (wrEntry),
    .rdAddr (rdAddr),
    .rdData (rdEntry)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      VALID <= 1'b0;
      ECD   <= '0;
      SRC   <= '0;
`ifdef ERRFIFO_TSTAMP_EN
      ETS   <= '0;
`endif
    end else if (outLoad) begin
      VALID <= dataOk;
      if (dataOk) begin
        ECD <= rdEntry.code;
        SRC <= rdEntry.src;
`ifdef ERRFIFO_TSTAMP_EN
        ETS <= rdEntry.ts;
`endif
      end
    end
  end

`ifdef ERRFIFO_TSTAMP_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) tsCnt <= '0;
    else       tsCnt <= tsCnt + TSW'(1);
  end
`endif

  // Clear applies first, so an event on the same edge leaves the counter at the event count.
  always_comb begin
    dropsNext = CLR ? 32'd0 : 32'(DROPS);
    if (drop) dropsNext = satInc(dropsNext, 32'd1, CNT_MAX);
    lostNext = CLR ? 32'd0 : 32'(LOST);
    if (rejectCnt != '0) lostNext = satInc(lostNext, 32'(rejectCnt), CNT_MAX);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      OVF   <= 1'b0;
      DROPS <= '0;
      LOST  <= '0;
    end else begin
      OVF   <= drop || (OVF && !CLR);
      DROPS <= dropsNext[CW-1:0];
      LOST  <= lostNext[CW-1:0];
    end
  end

endmodule

// File: tb/tb_error_fifo_arb.sv
// tb/tb_error_fifo_arb.sv - directed self-checking bench for error_fifo_arb (AW=2, N_SRC=5).
// ERRFIFO_TSTAMP_EN enables the timestamp step.
module tb_error_fifo_arb;

  logic          CLK;
  logic          RESET;
  logic [4:0]    STB;
  logic [319:0]  ECD_IN;
  logic          ERD;
  logic          VALID;
  logic [63:0]   ECD;
  logic [2:0]    SRC;
  logic [2:0]    COUNT;
  logic          OVF;
  logic [7:0]    DROPS;
  logic [7:0]    LOST;
  logic          CLR;
`ifdef ERRFIFO_TSTAMP_EN
  logic [31:0]   ETS;
  logic [31:0]   ets0;
`endif

  int nCmp = 0;
  int nFail = 0;

  error_fifo_arb #(
    .N_SRC (5),
    .DW    (64),
    .AW    (2),
    .CW    (8)
  ) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .STB    (STB),
    .ECD_IN (ECD_IN),
    .ERD    (ERD),
    .VALID  (VALID),
    .ECD    (ECD),
`ifdef ERRFIFO_TSTAMP_EN
    .ETS    (ETS),
`endif
    .SRC    (SRC),
    .COUNT  (COUNT),
    .OVF    (OVF),
    .DROPS  (DROPS),
    .LOST   (LOST),
    .CLR    (CLR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    RESET = 1'b1; STB = '0; ECD_IN = '0; ERD = 1'b0; CLR = 1'b0;
    tick(); tick();
    check("rst_valid", 64'(VALID), 64'd0);
    check("rst_count", 64'(COUNT), 64'd0);
    check("rst_ecd",   ECD,        64'd0);
    check("rst_ovf",   64'(OVF),   64'd0);
    check("rst_drops", 64'(DROPS), 64'd0);
    check("rst_lost",  64'(LOST),  64'd0);
    RESET = 1'b0;
    tick();

    // single report, source 2
    STB = 5'b00100; ECD_IN[2*64 +: 64] = 64'hDEAD;
    tick(); STB = '0;
    check("t1_count_t0", 64'(COUNT), 64'd0);
    tick();
    check("t1_count_t1", 64'(COUNT), 64'd1);
    check("t1_valid_t1", 64'(VALID), 64'd0);
    tick();
    check("t1_valid_t2", 64'(VALID), 64'd0);
    check("t1_count_t2", 64'(COUNT), 64'd1);
    tick();
    check("t1_valid_t3", 64'(VALID), 64'd1);
    check("t1_ecd",      ECD,        64'hDEAD);
    check("t1_src",      64'(SRC),   64'd2);
    check("t1_count_t3", 64'(COUNT), 64'd0);
    ERD = 1'b1; tick(); ERD = 1'b0;
    check("t1_popped", 64'(VALID), 64'd0);

    // priority 0,3,4
    STB = 5'b11001;
    ECD_IN[0*64 +: 64] = 64'hA0; ECD_IN[3*64 +: 64] = 64'hA3; ECD_IN[4*64 +: 64] = 64'hA4;
    tick(); STB = '0;
    tick(); tick(); tick();
    check("t2_valid", 64'(VALID), 64'd1);
    check("t2_src0",  64'(SRC),   64'd0);
    check("t2_ecd0",  ECD,        64'hA0);
    ERD = 1'b1; tick();
    check("t2_src3",  64'(SRC),   64'd3);
    check("t2_ecd3",  ECD,        64'hA3);
    tick();
    check("t2_src4",  64'(SRC),   64'd4);
    check("t2_ecd4",  ECD,        64'hA4);
    tick(); ERD = 1'b0;
    check("t2_empty", 64'(VALID), 64'd0);
    check("t2_lost",  64'(LOST),  64'd0);

    // lost report on busy source 1
    STB = 5'b00011; ECD_IN[0*64 +: 64] = 64'hB0; ECD_IN[1*64 +: 64] = 64'hC1;
    tick();
    ECD_IN[0*64 +: 64] = 64'hB1; ECD_IN[1*64 +: 64] = 64'hC2;
    tick(); STB = '0;
    check("t3_lost", 64'(LOST), 64'd1);
    tick(); tick();
    check("t3_valid", 64'(VALID), 64'd1);
    check("t3_ecd_a", ECD,        64'hB0);
    ERD = 1'b1; tick();
    check("t3_ecd_b", ECD,        64'hB1);
    check("t3_src_b", 64'(SRC),   64'd0);
    tick();
    check("t3_ecd_c", ECD,        64'hC1);
    check("t3_src_c", 64'(SRC),   64'd1);
    tick(); ERD = 1'b0;
    check("t3_empty", 64'(VALID), 64'd0);
    CLR = 1'b1; tick(); CLR = 1'b0;
    check("t3_lost_clr", 64'(LOST), 64'd0);

    // fill AW=2 FIFO: 4 in RAM + 1 in output, sixth dropped
    STB = 5'b11111;
    for (int i = 0; i < 5; i++) ECD_IN[i*64 +: 64] = 64'hF0 + 64'(i);
    tick(); STB = '0;
    tick(); tick(); tick();
    check("t4_valid",    64'(VALID), 64'd1);
    check("t4_count_rw", 64'(COUNT), 64'd2);
    tick(); tick();
    check("t4_count_full", 64'(COUNT), 64'd4);
    check("t4_ovf_pre",    64'(OVF),   64'd0);
    STB = 5'b00001; ECD_IN[0*64 +: 64] = 64'hF5;
    tick(); STB = '0;
    tick();
    check("t4_ovf",   64'(OVF),   64'd1);
    check("t4_drops", 64'(DROPS), 64'd1);
    check("t4_count", 64'(COUNT), 64'd4);
    CLR = 1'b1; tick(); CLR = 1'b0;
    check("t4_ovf_clr",   64'(OVF),   64'd0);
    check("t4_drops_clr", 64'(DROPS), 64'd0);

    // stream out with ERD held; pointers wrap
    check("t5_head", ECD, 64'hF0);
    ERD = 1'b1;
    for (int k = 1; k < 5; k++) begin
      tick();
      check("t5_ecd",   ECD,        64'hF0 + 64'(k));
      check("t5_src",   64'(SRC),   64'(k));
      check("t5_count", 64'(COUNT), 64'(4 - k));
    end
    tick(); ERD = 1'b0;
    check("t5_empty", 64'(VALID), 64'd0);

    // saturation of LOST and DROPS
    STB = 5'b00011;
    for (int k = 0; k < 300; k++) tick();
    check("sat_lost",  64'(LOST),  64'd255);
    check("sat_drops", 64'(DROPS), 64'd255);
    check("sat_ovf",   64'(OVF),   64'd1);
    CLR = 1'b1; tick(); CLR = 1'b0;
    check("clr_evt_lost",  64'(LOST),  64'd1);
    check("clr_evt_drops", 64'(DROPS), 64'd1);
    check("clr_evt_ovf",   64'(OVF),   64'd1);
    STB = '0;
    tick(); tick();
    CLR = 1'b1; tick(); CLR = 1'b0;
    check("clr_ovf",   64'(OVF),   64'd0);
    check("clr_drops", 64'(DROPS), 64'd0);
    check("clr_lost",  64'(LOST),  64'd0);

    // reset mid-stream
    ERD = 1'b1; tick(); ERD = 1'b0;
    check("t6_valid_pre", 64'(VALID), 64'd1);
    check("t6_count_pre", 64'(COUNT), 64'd3);
    RESET = 1'b1; #2;
    check("t6_valid", 64'(VALID), 64'd0);
    check("t6_count", 64'(COUNT), 64'd0);
    check("t6_ecd",   ECD,        64'd0);
    check("t6_src",   64'(SRC),   64'd0);
    tick(); RESET = 1'b0;
    STB = 5'b10000; ECD_IN[4*64 +: 64] = 64'h55;
    tick(); STB = '0;
    tick(); tick(); tick();
    check("t6_post_valid", 64'(VALID), 64'd1);
    check("t6_post_src",   64'(SRC),   64'd4);
    check("t6_post_ecd",   ECD,        64'h55);
    ERD = 1'b1; tick(); ERD = 1'b0;

`ifdef ERRFIFO_TSTAMP_EN
    STB = 5'b00001; ECD_IN[0*64 +: 64] = 64'h71;
    tick(); STB = '0;
    for (int k = 0; k < 9; k++) tick();
    STB = 5'b00001; ECD_IN[0*64 +: 64] = 64'h72;
    tick(); STB = '0;
    tick(); tick(); tick();
    check("t7_ecd_a", ECD, 64'h71);
    ets0 = ETS;
    ERD = 1'b1; tick(); ERD = 1'b0;
    check("t7_ecd_b", ECD, 64'h72);
    check("t7_ets_diff", 64'(ETS - ets0), 64'd10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
